matvec_mac: RTL and testbench
=============================

MATVEC_MAC -- requirements
Module: matvec_mac

Interface
REQ-001 Parameter NROW, 16, number of output rows; SHALL be a multiple of ROWS_PER_MAC.
REQ-002 Parameter NCOL, 16, number of input-vector elements (columns), >=1.
REQ-003 Parameter QN, 6, integer bits of the fixed-point format (sign bit excluded).
REQ-004 Parameter QM, 11, fractional bits; data width W = QN+QM+1, two's complement.
REQ-005 Parameter ROWS_PER_MAC, 2, rows time-shared by one multiplier; N_MAC = NROW/ROWS_PER_MAC.
REQ-006 Parameter SATURATE, 1, 1 = clamp the result to the W-bit range, 0 = truncate (wrap).
REQ-007 clk  input  1  clock; all logic rising-edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 start  input  1  single-cycle request to begin one matrix-vector product.
REQ-010 bias_in  input  NROW*W  per-row bias, row r at [r*W +: W]; sampled on the accepted start.
REQ-011 weight_row  input  NROW*W  column col_addr of the weight matrix, row r at [r*W +: W]; valid combinationally in the same cycle.
REQ-012 x_in  input  W  element col_addr of the input vector; valid combinationally in the same cycle.
REQ-013 col_addr  output  clog2(NCOL) (min 1)  current column index.
REQ-014 busy  output  1  high from the cycle after an accepted start until done.
REQ-015 done  output  1  one-cycle pulse; y_out and sat are valid from this cycle on.
REQ-016 y_out  output  NROW*W  result y = W·x + b; row r at [r*W +: W]; held until the next done.
REQ-017 sat  output  1  high if any row saturated or wrapped in the run; valid with done.

Function
REQ-018 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-019 IDLE->CALC on start; start SHALL be ignored in CALC and DONE.
REQ-020 On start, accumulator r SHALL load sign-extended bias_in[r] << QM; phase and col_addr SHALL clear to 0.
REQ-021 CALC SHALL step col_addr 0..NCOL-1 (inner loop) for each phase 0..ROWS_PER_MAC-1 (outer loop), for exactly NCOL*ROWS_PER_MAC cycles.
REQ-022 Each CALC cycle, MAC i SHALL add full-precision product weight_row[i*ROWS_PER_MAC+phase] * x_in into accumulator (i*ROWS_PER_MAC+phase).
REQ-023 Accumulator width SHALL be 2W + clog2(NCOL+1) + 1, so no internal overflow is possible.
REQ-024 On the last CALC cycle (col_addr=NCOL-1, phase=ROWS_PER_MAC-1), the FSM SHALL go to DONE.
REQ-025 At that edge, y_out[r] SHALL be loaded with acc[r] >>> QM (arithmetic shift), then clamped to [-2^(W-1), 2^(W-1)-1] if SATURATE=1, or low W bits kept otherwise.
REQ-026 sat SHALL be the OR over rows of "shifted value out of W-bit range".
REQ-027 DONE SHALL last one cycle with done=1, then return to IDLE; col_addr SHALL be 0 in IDLE and DONE.
REQ-028 Latency from start high to done high SHALL be NCOL*ROWS_PER_MAC+1 cycles.
REQ-029 A start in the DONE cycle SHALL be ignored; back-to-back runs need start in IDLE.

Reset
REQ-030 Reset SHALL force IDLE, with col_addr=0, phase=0, busy=0, done=0, y_out=0, sat=0, and accumulators=0.
REQ-031 Reset during CALC SHALL abort the run; no done SHALL follow, and y_out SHALL read 0.

Structure
REQ-032 Package matvec_pkg SHALL hold the state encoding and the width functions (W, accumulator width, address width).
REQ-033 One sub-module, mac_lane, SHALL contain one multiplier plus its ROWS_PER_MAC accumulators and the final shift/saturate; it SHALL be instantiated N_MAC times.

Verification
REQ-034 Identity test: NROW=NCOL=4, ROWS_PER_MAC=2, W=I·2048, x=[2048,4096,-2048,1024], b=0 -> y_out=[2048,4096,-2048,1024], done exactly 9 cycles after start, sat=0.
REQ-035 Bias and negative weights: all weights=-2048, x all 1024, b all 512 -> every row = 512 - 4*1024 = -3584.
REQ-036 Saturation: all weights=x=131071 (max), SATURATE=1 -> every row = 131071, sat=1; with SATURATE=0 -> wrapped low W bits, sat=1.
REQ-037 Reset mid-run: assert reset at CALC cycle 3 -> no done pulse, y_out=0, busy=0; a new start then yields a correct result.
REQ-038 Ignored start: pulse start during CALC and during DONE -> single done, result unchanged; ROWS_PER_MAC=1 and NCOL=1 corner runs -> latency 2.

Source files
------------

// File: rtl/matvec_pkg.sv
// matvec_pkg: FSM encoding and width helpers shared by the matrix-vector MAC files
package matvec_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    function automatic int data_w(input int qn, input int qm);
        return qn + qm + 1;
    endfunction
    function automatic int acc_w(input int w, input int ncol);
        return 2 * w + $clog2(ncol + 1) + 1;
    endfunction
    function automatic int addr_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/matvec_mac_if.sv
// matvec_mac_if: start/column-fetch/result bus between the MAC engine and its host
interface matvec_mac_if #(
    parameter int NROW = 16,
    parameter int W = 18,
    parameter int CW = 4
);
    logic start;
    logic [NROW*W-1:0] bias_in;
    logic [NROW*W-1:0] weight_row;
    logic [W-1:0] x_in;
    logic [CW-1:0] col_addr;
    logic busy;
    logic done;
    logic [NROW*W-1:0] y_out;
    logic sat;
    modport master(output start, bias_in, weight_row, x_in, input col_addr, busy, done, y_out, sat);
    modport slave(input start, bias_in, weight_row, x_in, output col_addr, busy, done, y_out, sat);
endinterface

// File: rtl/mac_lane.sv
// mac_lane: one multiplier time-shared across RPM row accumulators, with final shift and clamp/wrap
module mac_lane
    import matvec_pkg::*;
#(
    parameter int W = 18,
    parameter int QM = 11,
    parameter int AW = 42,
    parameter int RPM = 2,
    parameter int SATURATE = 1,
    localparam int PW = addr_w(RPM)
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    input  logic last,
    input  logic [PW-1:0] phase,
    input  logic [RPM*W-1:0] bias,
    input  logic [RPM*W-1:0] weight,
    input  logic [W-1:0] x,
    output logic [RPM*W-1:0] y,
    output logic sat
);
    logic signed [W-1:0] w_sel;
    logic signed [2*W-1:0] prod;
    logic signed [AW-1:0] acc [RPM];
    logic signed [AW-1:0] nxt [RPM];
    logic signed [AW-1:0] sh [RPM];
    logic signed [W-1:0] lo [RPM];
    logic [RPM-1:0] ovf;
    logic [RPM*W-1:0] res;
    assign w_sel = weight[int'(phase)*W +: W];
    assign prod = w_sel * $signed(x);
    // the final column's product is folded in combinationally so y loads on the same edge
    always_comb begin
        ovf = '0;
        res = '0;
        for (int k = 0; k < RPM; k++) begin
            nxt[k] = acc[k] + ((en && int'(phase) == k) ? AW'(prod) : AW'(0));
            sh[k] = nxt[k] >>> QM;
            lo[k] = sh[k][W-1:0];
            ovf[k] = sh[k] != AW'(lo[k]);
            res[k*W +: W] = (SATURATE != 0 && ovf[k]) ?
                (sh[k][AW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}}) : lo[k];
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < RPM; k++) acc[k] <= '0;
            y <= '0;
            sat <= 1'b0;
        end else begin
            for (int k = 0; k < RPM; k++)
                acc[k] <= load ? (AW'($signed(bias[k*W +: W])) <<< QM) : nxt[k];
            if (last) begin
                y <= res;
                sat <= |ovf;
            end
        end
    end
endmodule

// File: rtl/matvec_mac.sv
// matvec_mac: fixed-point y = W*x + b, one column per cycle, N_MAC lanes each serving ROWS_PER_MAC rows
module matvec_mac
    import matvec_pkg::*;
#(
    parameter int NROW = 16,
    parameter int NCOL = 16,
    parameter int QN = 6,
    parameter int QM = 11,
    parameter int ROWS_PER_MAC = 2,
    parameter int SATURATE = 1
) (
    input logic clk,
    input logic reset,
    matvec_mac_if.slave bus
);
    localparam int W = data_w(QN, QM);
    localparam int AW = acc_w(W, NCOL);
    localparam int CW = addr_w(NCOL);
    localparam int PW = addr_w(ROWS_PER_MAC);
    localparam int N_MAC = NROW / ROWS_PER_MAC;
    localparam int LW = ROWS_PER_MAC * W;
    state_t state;
    logic [PW-1:0] phase;
    logic [CW-1:0] col;
    logic busy, done, load, en, last;
    logic [N_MAC-1:0] lane_sat;
    logic [NROW*W-1:0] y;
    assign load = state == IDLE && bus.start;
    assign en = state == CALC;
    assign last = en && col == CW'(NCOL - 1) && phase == PW'(ROWS_PER_MAC - 1);
    assign bus.col_addr = col;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.y_out = y;
    assign bus.sat = |lane_sat;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            phase <= '0;
            col <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    state <= CALC;
                    busy <= 1'b1;
                    phase <= '0;
                    col <= '0;
                end
                CALC: begin
                    col <= col == CW'(NCOL - 1) ? '0 : col + 1'b1;
                    phase <= col == CW'(NCOL - 1) ? phase + 1'b1 : phase;
                    if (last) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                        phase <= '0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    for (genvar i = 0; i < N_MAC; i++) begin : g_lane
        mac_lane #(.W(W), .QM(QM), .AW(AW), .RPM(ROWS_PER_MAC), .SATURATE(SATURATE)) u_lane (
            .clk(clk),
            .reset(reset),
            .load(load),
            .en(en),
            .last(last),
            .phase(phase),
            .bias(bus.bias_in[i*LW +: LW]),
            .weight(bus.weight_row[i*LW +: LW]),
            .x(bus.x_in),
            .y(y[i*LW +: LW]),
            .sat(lane_sat[i])
        );
    end
endmodule

// File: tb/tb_matvec_mac.sv
// tb_matvec_mac: scoreboard bench over saturating, wrapping and single-column matvec_mac builds
module tb_matvec_mac;
    typedef struct {logic [71:0] y; logic sat; int lat;} exp_t;
    logic clk = 0, reset = 1;
    int cyc = 0, n_cmp = 0, n_bad = 0, st_ab = 0, st_c = 0;
    logic start_ab = 0, start_c = 0;
    logic [71:0] bias_ab = '0, id_y = '0;
    logic [35:0] bias_c = '0, wc = '0;
    logic [17:0] xc = '0;
    logic [71:0] wm [4];
    logic [17:0] xm [4];
    exp_t qa[$], qb[$], qc[$];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    matvec_mac_if #(.NROW(4), .W(18), .CW(2)) ia();
    matvec_mac_if #(.NROW(4), .W(18), .CW(2)) ib();
    matvec_mac_if #(.NROW(2), .W(18), .CW(1)) ic();
    assign ia.start = start_ab;
    assign ia.bias_in = bias_ab;
    assign ia.weight_row = wm[ia.col_addr];
    assign ia.x_in = xm[ia.col_addr];
    assign ib.start = start_ab;
    assign ib.bias_in = bias_ab;
    assign ib.weight_row = wm[ib.col_addr];
    assign ib.x_in = xm[ib.col_addr];
    assign ic.start = start_c;
    assign ic.bias_in = bias_c;
    assign ic.weight_row = wc;
    assign ic.x_in = xc;
    matvec_mac #(.NROW(4), .NCOL(4), .QN(6), .QM(11), .ROWS_PER_MAC(2), .SATURATE(1)) u_a (.clk(clk), .reset(reset), .bus(ia.slave));
    matvec_mac #(.NROW(4), .NCOL(4), .QN(6), .QM(11), .ROWS_PER_MAC(2), .SATURATE(0)) u_b (.clk(clk), .reset(reset), .bus(ib.slave));
    matvec_mac #(.NROW(2), .NCOL(1), .QN(6), .QM(11), .ROWS_PER_MAC(1), .SATURATE(1)) u_c (.clk(clk), .reset(reset), .bus(ic.slave));

    function automatic logic [71:0] pk(input int a, input int b, input int c, input int d);
        return {18'(d), 18'(c), 18'(b), 18'(a)};
    endfunction
    function automatic exp_t mk(input logic [71:0] y, input logic s, input int lat);
        exp_t e;
        e.y = y;
        e.sat = s;
        e.lat = lat;
        return e;
    endfunction
    task automatic cmp(input string nm, input logic [71:0] got, input logic [71:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, got, want);
        end
    endtask
    task automatic score(input string nm, input logic [71:0] y, input logic s, input int lat, input exp_t e);
        cmp({nm, "_y"}, y, e.y);
        cmp({nm, "_sat"}, 72'(s), 72'(e.sat));
        cmp({nm, "_latency"}, 72'(lat), 72'(e.lat));
    endtask
    task automatic extra(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s_extra_done: got done at cycle %0d, required none", nm, cyc);
    endtask

    always @(negedge clk) if (ia.done) begin
        if (qa.size() == 0) extra("a");
        else score("a", ia.y_out, ia.sat, cyc - st_ab, qa.pop_front());
    end
    always @(negedge clk) if (ib.done) begin
        if (qb.size() == 0) extra("b");
        else score("b", ib.y_out, ib.sat, cyc - st_ab, qb.pop_front());
    end
    always @(negedge clk) if (ic.done) begin
        if (qc.size() == 0) extra("c");
        else score("c", {36'b0, ic.y_out}, ic.sat, cyc - st_c, qc.pop_front());
    end

    task automatic set_all(input int wv, input int xv);
        for (int c = 0; c < 4; c++) begin
            wm[c] = {4{18'(wv)}};
            xm[c] = 18'(xv);
        end
    endtask
    task automatic set_id();
        for (int c = 0; c < 4; c++) begin
            wm[c] = '0;
            wm[c][c*18 +: 18] = 18'd2048;
        end
        xm[0] = 18'(2048);
        xm[1] = 18'(4096);
        xm[2] = 18'(-2048);
        xm[3] = 18'(1024);
    endtask
    task automatic run_ab(input logic [71:0] b, input exp_t ea, input exp_t eb, input bit poke);
        int n = 0;
        bias_ab = b;
        qa.push_back(ea);
        qb.push_back(eb);
        @(posedge clk); #1 start_ab = 1; st_ab = cyc;
        @(posedge clk); #1 start_ab = 0;
        cmp("ab_busy", 72'({ia.busy, ib.busy}), 72'(3));
        if (poke) begin
            @(posedge clk); #1 start_ab = 1;
            @(posedge clk); #1 start_ab = 0;
        end
        while (!ia.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        cmp("ab_done_seen", 72'(ia.done), 72'(1));
        if (poke) start_ab = 1;
        @(posedge clk); #1 start_ab = 0;
        repeat (poke ? 12 : 2) @(posedge clk);
        #1;
    endtask
    task automatic run_c(input logic [35:0] b, input logic [35:0] w, input logic [17:0] x, input exp_t e);
        int n = 0;
        bias_c = b;
        wc = w;
        xc = x;
        qc.push_back(e);
        @(posedge clk); #1 start_c = 1; st_c = cyc;
        @(posedge clk); #1 start_c = 0;
        while (!ic.done && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        cmp("c_done_seen", 72'(ic.done), 72'(1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        id_y = pk(2048, 4096, -2048, 1024);
        for (int c = 0; c < 4; c++) begin
            wm[c] = '0;
            xm[c] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_flags", 72'({ia.busy, ia.done, ia.sat, ib.busy, ib.done, ib.sat, ic.busy, ic.done, ic.sat}), 72'(0));
        cmp("rst_y_a", ia.y_out, 72'(0));
        cmp("rst_col", 72'({ia.col_addr, ic.col_addr}), 72'(0));
        reset = 0;
        set_id();
        run_ab(72'(0), mk(id_y, 1'b0, 9), mk(id_y, 1'b0, 9), 1'b0);
        set_all(-2048, 1024);
        run_ab(pk(512, 512, 512, 512), mk(pk(-3584, -3584, -3584, -3584), 1'b0, 9),
               mk(pk(-3584, -3584, -3584, -3584), 1'b0, 9), 1'b0);
        set_all(1024, 2048);
        xm[3] = 18'(-2048);
        run_ab(pk(0, -1, 100, -131072), mk(pk(2048, 2047, 2148, -129024), 1'b0, 9),
               mk(pk(2048, 2047, 2148, -129024), 1'b0, 9), 1'b0);
        set_all(1, -1);
        run_ab(72'(0), mk(pk(-1, -1, -1, -1), 1'b0, 9), mk(pk(-1, -1, -1, -1), 1'b0, 9), 1'b0);
        set_all(131071, 131071);
        run_ab(72'(0), mk(pk(131071, 131071, 131071, 131071), 1'b1, 9),
               mk(pk(-512, -512, -512, -512), 1'b1, 9), 1'b0);
        set_all(-2048, 2048);
        run_ab(pk(-131072, 0, 0, 0), mk(pk(-131072, -8192, -8192, -8192), 1'b1, 9),
               mk(pk(122880, -8192, -8192, -8192), 1'b1, 9), 1'b0);
        set_id();
        run_ab(72'(0), mk(id_y, 1'b0, 9), mk(id_y, 1'b0, 9), 1'b1);
        cmp("a_y_held", ia.y_out, id_y);
        @(posedge clk); #1 start_ab = 1; st_ab = cyc;
        @(posedge clk); #1 start_ab = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        cmp("abort_busy_done", 72'({ia.busy, ia.done, ib.busy, ib.done}), 72'(0));
        cmp("abort_y_a", ia.y_out, 72'(0));
        cmp("abort_y_b", ib.y_out, 72'(0));
        cmp("abort_col", 72'(ia.col_addr), 72'(0));
        repeat (12) @(posedge clk);
        #1;
        run_ab(72'(0), mk(id_y, 1'b0, 9), mk(id_y, 1'b0, 9), 1'b0);
        run_c({18'(-7), 18'(5)}, {18'(-1024), 18'(6144)}, 18'(2048), mk(72'({18'(-1031), 18'(6149)}), 1'b0, 2));
        run_c(36'(0), {18'(0), 18'(131071)}, 18'(131071), mk(72'({18'(0), 18'(131071)}), 1'b1, 2));
        run_c(36'(0), {18'(-131072), 18'(0)}, 18'(131071), mk(72'({18'(-131072), 18'(0)}), 1'b1, 2));
        cmp("queues_empty", 72'(qa.size() + qb.size() + qc.size()), 72'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
